// File: rtl/sseg_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
// Imported by the arbiter top and its round-robin picker.
package sseg_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DWELL_DEF = 50_000_000;
  localparam int DISP_W    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first candidate strictly after `last`,
// wrapping, so `last` itself is considered only after all others.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic [N-1:0]  excl,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  cand;
  logic [IW-1:0] j;

  assign cand = req & ~excl;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(last) + i) % N);
      if (!valid && cand[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/sseg_arb.sv
// Round-robin owner arbitration for a shared 16-bit seven-segment display,
// holding each grant for DWELL cycles and registering the owner's value.
module sseg_arb
  import sseg_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DWELL = DWELL_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [DISP_W*NREQ-1:0]   data,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [DISP_W-1:0]        disp_val,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DISP_W-1:0] disp_q, disp_d;

  logic            expire;
  logic            own_req;
  logic            drop;
  logic [NREQ-1:0] excl;
  logic            pick_v;
  logic [IW-1:0]   pick_idx;
  logic [DISP_W-1:0] sel;

  assign expire  = (state_q == SHOW) && (cnt_q == '0);
  assign own_req = |(req & grant_q);
  assign drop    = (state_q == SHOW) && !expire && !own_req;
  assign excl    = drop ? grant_q : '0;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last_q),
    .excl  (excl),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == IDLE) || expire || drop: begin
        if (pick_v) begin
          state_d = SHOW;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
          cnt_d   = '0;
        end
      end
      default: cnt_d = cnt_q - CW'(1);
    endcase
  end

  // Mux on the next owner so the display value lands with the grant.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_d == IW'(k)) sel = data[k*DISP_W +: DISP_W];
    end
    disp_d = (state_d == SHOW) ? sel : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  assign grant    = grant_q;
  assign done     = expire ? grant_q : '0;
  assign disp_val = disp_q;
  assign owner    = owner_q;

endmodule

// File: doc/sseg_arb.md
SSEG_ARB -- requirements
Module: sseg_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter DWELL, default 50_000_000, meaning the display hold time in clk cycles per grant (>=1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req, input, NREQ bits: a level request per requester to own the display.
REQ-006 The block SHALL have port data, input, 16*NREQ bits: the 16-bit display value of requester i, held at bits [16i+15:16i].
REQ-007 The block SHALL have port grant, output, NREQ bits: one-hot or zero, marking the current display owner.
REQ-008 The block SHALL have port done, output, NREQ bits: a one-cycle pulse on the owner's bit when its dwell expires.
REQ-009 The block SHALL have port disp_val, output, 16 bits: the value driven to the seven-segment driver's 16-bit input.
REQ-010 The block SHALL have port owner, output, clog2(NREQ) bits: the index of the current owner, valid while |grant.

Function
REQ-011 The state machine SHALL have exactly two states, IDLE (no owner) and SHOW (one owner, dwell counter running).
REQ-012 IDLE->SHOW: when |req is sampled at edge t, grant SHALL be one-hot at t+1 and the counter SHALL be loaded with DWELL-1.
REQ-013 Winner selection SHALL be round-robin: the first asserted req scanning from index last+1 upward, wrapping at NREQ; last SHALL be NREQ-1 after reset, so index 0 wins first.
REQ-014 In SHOW, disp_val SHALL be the registered data slice of the owner, i.e. data sampled at t appears at t+1, and SHALL track live changes with that 1-cycle latency.
REQ-015 In IDLE, disp_val SHALL be 16'h0000.
REQ-016 In SHOW, the counter SHALL decrement by 1 per cycle; at count==0, done[owner] SHALL pulse for exactly one cycle.
REQ-017 At expiry, if another requester is pending, grant SHALL move in the next cycle to the round-robin winner, with no IDLE gap.
REQ-018 At expiry, if only the owner requests, the owner SHALL retain grant and the counter SHALL reload to DWELL-1; done pulses again every DWELL cycles.
REQ-019 At expiry, if no requester is pending, the block SHALL enter IDLE.
REQ-020 If the owner drops req before expiry, grant SHALL release at the next edge with no done pulse; re-arbitration happens in that same cycle per REQ-013, excluding the dropped owner.
REQ-021 Requests from non-owners SHALL never preempt the owner before expiry.
REQ-022 With DWELL==1, the counter SHALL be 0 every SHOW cycle, so done pulses every cycle and rotation occurs every cycle when others are pending.
REQ-023 The counter width SHALL be clog2(DWELL+1); no wrap-around below 0 is permitted.

Reset
REQ-024 On any clk edge with rst_n==0, the block SHALL set: state=IDLE; grant=0; done=0; disp_val=16'h0000; owner=0; counter=0; last=NREQ-1.
REQ-025 Reset asserted mid-SHOW SHALL abort the grant with no done pulse; the first arbitration after release SHALL follow REQ-012 and REQ-013.

Structure
REQ-026 A shared package sseg_pkg SHALL hold the default NREQ, DWELL, DISP_W=16, and the state encoding constants.
REQ-027 Round-robin selection SHALL be a purely combinational sub-module rr_pick (inputs req, last, optional exclude mask; outputs valid, idx).
REQ-028 The top level SHALL instantiate sseg_arb ahead of sseg, feeding disp_val to sseg's 16-bit input.

Verification (NREQ=4, DWELL=4 unless stated)
REQ-029 Reset then req=4'b0001, data0=16'h1234 -> grant=0001 and disp_val=1234 one cycle later; done[0] pulses every 4 cycles.
REQ-030 req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001, each held 4 cycles; done pulses precede each handover.
REQ-031 Owner 0 drops req 2 cycles into dwell with req[2] high -> grant=0100 the next cycle; no done[0] pulse.
REQ-032 rst_n low for 1 cycle mid-SHOW -> all outputs zero the next cycle; after release with req=1111, grant=0001.
REQ-033 DWELL=1, req=0011 -> grant alternates 01/10 every cycle; done toggles owner bit every cycle.
REQ-034 req=0 after expiry -> IDLE, disp_val=0000, grant=0.
